// File: rtl/wide_add_sequencer.sv
// Multi-byte add/subtract sequencer driving an external 8-bit ripple-carry adder,
// one byte per clock LSB first, with carry chaining and signed overflow detection.
module wide_add_sequencer #(
    parameter  int NBYTES = 4,
    localparam int W      = 8 * NBYTES,
    localparam int IW     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sub,
    input  logic         cin_in,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic [7:0]   add_a,
    output logic [7:0]   add_b,
    output logic         add_cin,
    input  logic [7:0]   add_sum,
    input  logic         add_cout,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         ovf
);

    // state | meaning
    // IDLE  | waiting for start; adder inputs held at zero
    // RUN   | one byte per clock through the external adder, idx selects the byte
    // DONE  | one-cycle result-valid pulse, then back to IDLE
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [NBYTES-1:0][7:0]  a_reg, b_reg, res_reg;
    logic [IW-1:0]           idx;
    logic                    carry;
    logic                    last;

    assign last   = (idx == IW'(NBYTES - 1));
    assign result = res_reg;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        add_a   = 8'h00;
        add_b   = 8'h00;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[idx];
            add_b   = b_reg[idx];
            add_cin = carry;
        end
    end

    // Subtraction is folded into the operand capture: B is inverted and carry seeded with 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            idx     <= '0;
            carry   <= 1'b0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg   <= op_a;
                        b_reg   <= sub ? ~op_b : op_b;
                        carry   <= sub ? 1'b1 : cin_in;
                        idx     <= '0;
                        res_reg <= '0;
                        cout    <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                RUN: begin
                    res_reg[idx] <= add_sum;
                    carry        <= add_cout;
                    if (last) begin
                        cout <= add_cout;
                        ovf  <= (add_a[7] == add_b[7]) && (add_sum[7] != add_a[7]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
